// File: rtl/rvfi_dii_trace_sequencer.sv
// rvfi_dii_trace_sequencer: buffers DII packets, injects instructions into the generator and runs the end-of-trace drain/reset/done sequence
module rvfi_dii_trace_sequencer #(
  parameter int FifoDepth     = 4,
  parameter int NrCommitPorts = 2,
  parameter int MaxInflight   = 16,
  parameter int RstCycles     = 8,
  parameter int DrainTimeout  = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             pkt_valid_i,
  input  logic                             pkt_cmd_i,
  input  logic [31:0]                      pkt_insn_i,
  output logic                             pkt_ready_o,
  output logic                             gen_vld_o,
  output logic [31:0]                      gen_insn_o,
  input  logic                             gen_ready_i,
  input  logic [NrCommitPorts-1:0]         retire_valid_i,
  output logic                             core_rst_o,
  output logic                             trace_done_o,
  output logic [$clog2(MaxInflight+1)-1:0] inflight_o,
  output logic                             err_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam int IW = $clog2(MaxInflight + 1);
  localparam int PW = $clog2(NrCommitPorts + 1);
  localparam int DW = $clog2(DrainTimeout + 1);
  localparam int RW = $clog2(RstCycles + 1);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_RESET, S_DONE} state_e;
  state_e        st_q, st_d;
  logic [32:0]   mem_q [FifoDepth];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [IW-1:0] inf_q, inf_d;
  logic [DW-1:0] idle_q, idle_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          err_q, err_d;
  logic [32:0]   head;
  logic          push, pop, xfer, eot, any_ret, under, timeout;
  logic [PW-1:0] nret;
  logic [IW:0]   sum;
  assign head         = mem_q[rd_q];
  assign pkt_ready_o  = !rst_i && cnt_q != (AW+1)'(FifoDepth);
  assign push         = pkt_valid_i && pkt_ready_o;
  assign gen_vld_o    = !rst_i && st_q == S_RUN && cnt_q != '0 && head[32] && inf_q < IW'(MaxInflight);
  assign gen_insn_o   = rst_i ? '0 : head[31:0];
  assign xfer         = gen_vld_o && gen_ready_i;
  // An end-of-trace head is consumed without ever being offered to the generator
  assign eot          = !rst_i && st_q == S_RUN && cnt_q != '0 && !head[32];
  assign pop          = xfer || eot;
  assign any_ret      = |retire_valid_i;
  assign core_rst_o   = !rst_i && st_q == S_RESET;
  assign trace_done_o = !rst_i && st_q == S_DONE;
  assign inflight_o   = rst_i ? '0 : inf_q;
  assign err_o        = !rst_i && err_q;
  always_comb begin
    nret = '0;
    for (int i = 0; i < NrCommitPorts; i++) nret = nret + PW'(retire_valid_i[i]);
    sum     = {1'b0, inf_q} + (IW+1)'(xfer);
    under   = sum < (IW+1)'(nret);
    timeout = !any_ret && idle_q + DW'(1) == DW'(DrainTimeout);
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    st_d    = st_q;
    idle_d  = idle_q;
    rcnt_d  = rcnt_q;
    inf_d   = '0;
    err_d   = err_q;
    if (st_q == S_RUN || st_q == S_DRAIN) begin
      inf_d = under ? '0 : IW'(sum - (IW+1)'(nret));
      err_d = err_q || under;
    end
    if (st_q == S_RUN && eot) begin
      st_d   = S_DRAIN;
      idle_d = '0;
    end
    if (st_q == S_DRAIN) begin
      idle_d = any_ret ? '0 : idle_q + DW'(1);
      if (inf_q == '0 || timeout) begin
        st_d   = S_RESET;
        rcnt_d = '0;
        inf_d  = '0;
        err_d  = err_d || inf_q != '0;
      end
    end
    if (st_q == S_RESET) begin
      rcnt_d = rcnt_q + RW'(1);
      st_d   = rcnt_q == RW'(RstCycles - 1) ? S_DONE : S_RESET;
    end
    if (st_q == S_DONE) st_d = S_RUN;
  end
  always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= {pkt_cmd_i, pkt_insn_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= S_RUN;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      inf_q  <= '0;
      idle_q <= '0;
      rcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_q + AW'(push);
      rd_q   <= rd_q + AW'(pop);
      cnt_q  <= cnt_d;
      inf_q  <= inf_d;
      idle_q <= idle_d;
      rcnt_q <= rcnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_rvfi_dii_trace_sequencer.sv
// tb_rvfi_dii_trace_sequencer: vector table plus scoreboard of injected instruction words
module tb_rvfi_dii_trace_sequencer;
  logic        clk = 1'b0;
  logic        rst, pkt_valid, pkt_cmd, pkt_ready, gen_vld, gen_ready, core_rst, trace_done, err;
  logic [31:0] pkt_insn, gen_insn;
  logic [1:0]  retire;
  logic [4:0]  inflight;
  int          n_chk = 0, n_fail = 0, xfer_cnt = 0, rst_hi_cnt = 0, done_cnt = 0;
  logic [31:0] sb [$];
  typedef struct packed {
    logic        v;
    logic [31:0] insn;
    logic        gr;
    logic [1:0]  ret;
    logic        e_rdy;
    logic        e_vld;
    logic [4:0]  e_inf;
  } vec_t;
  vec_t tv [16];

  always #5 clk = ~clk;

  rvfi_dii_trace_sequencer dut (
    .clk_i(clk), .rst_i(rst), .pkt_valid_i(pkt_valid), .pkt_cmd_i(pkt_cmd), .pkt_insn_i(pkt_insn),
    .pkt_ready_o(pkt_ready), .gen_vld_o(gen_vld), .gen_insn_o(gen_insn), .gen_ready_i(gen_ready),
    .retire_valid_i(retire), .core_rst_o(core_rst), .trace_done_o(trace_done), .inflight_o(inflight),
    .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfers are compared against words queued when their packets were accepted
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (gen_vld && gen_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_extra: transfer %h with nothing expected", gen_insn);
        end else chk("sb_insn", gen_insn, sb.pop_front());
      end
      if (pkt_valid && pkt_ready && pkt_cmd) sb.push_back(pkt_insn);
      if (core_rst) rst_hi_cnt++;
      if (trace_done) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pkt_valid = 1'b0; pkt_cmd = 1'b0; pkt_insn = '0; gen_ready = 1'b0; retire = '0;
    cyc();
    cyc();
    rst = 1'b0; xfer_cnt = 0; rst_hi_cnt = 0; done_cnt = 0;
  endtask

  task automatic drive_push(input logic cmd, input logic [31:0] insn);
    pkt_valid = 1'b1; pkt_cmd = cmd; pkt_insn = insn;
    cyc();
    pkt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, n;
    logic acc, seen, prev_err;
    tv[0]  = '{1'b1, 32'h00000013, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0};
    tv[1]  = '{1'b1, 32'h00100093, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0};
    tv[2]  = '{1'b1, 32'h00200113, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0};
    tv[3]  = '{1'b1, 32'h00300193, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0};
    tv[4]  = '{1'b1, 32'h00400213, 1'b0, 2'b00, 1'b0, 1'b1, 5'd0};
    tv[5]  = '{1'b1, 32'h00400213, 1'b1, 2'b00, 1'b0, 1'b1, 5'd0};
    tv[6]  = '{1'b1, 32'h00400213, 1'b0, 2'b00, 1'b1, 1'b1, 5'd1};
    tv[7]  = '{1'b1, 32'h00500293, 1'b1, 2'b00, 1'b0, 1'b1, 5'd1};
    tv[8]  = '{1'b1, 32'h00500293, 1'b1, 2'b00, 1'b1, 1'b1, 5'd2};
    tv[9]  = '{1'b0, 32'h00000000, 1'b1, 2'b00, 1'b1, 1'b1, 5'd3};
    tv[10] = '{1'b0, 32'h00000000, 1'b1, 2'b11, 1'b1, 1'b1, 5'd4};
    tv[11] = '{1'b0, 32'h00000000, 1'b1, 2'b01, 1'b1, 1'b1, 5'd3};
    tv[12] = '{1'b0, 32'h00000000, 1'b0, 2'b00, 1'b1, 1'b0, 5'd3};
    tv[13] = '{1'b0, 32'h00000000, 1'b0, 2'b11, 1'b1, 1'b0, 5'd3};
    tv[14] = '{1'b0, 32'h00000000, 1'b0, 2'b01, 1'b1, 1'b0, 5'd1};
    tv[15] = '{1'b0, 32'h00000000, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0};

    rst = 1'b1; pkt_valid = 1'b1; pkt_cmd = 1'b1; pkt_insn = 32'h13; gen_ready = 1'b1; retire = '0;
    @(negedge clk);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_gen_vld", gen_vld, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_trace_done", trace_done, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    cyc();
    do_reset();

    // FIFO fill, full back-pressure, push+pop in one cycle, retire netting
    for (int i = 0; i < 16; i++) begin
      pkt_valid = tv[i].v; pkt_cmd = 1'b1; pkt_insn = tv[i].insn; gen_ready = tv[i].gr; retire = tv[i].ret;
      @(negedge clk);
      chk($sformatf("tv%0d_pkt_ready", i), pkt_ready, tv[i].e_rdy);
      chk($sformatf("tv%0d_gen_vld", i), gen_vld, tv[i].e_vld);
      chk($sformatf("tv%0d_inflight", i), inflight, tv[i].e_inf);
      cyc();
    end
    chk("tv_err", err, 0);
    chk("tv_xfers", xfer_cnt, 6);
    retire = 2'b11;
    cyc();
    retire = '0;
    chk("underflow_inflight", inflight, 0);
    chk("underflow_err", err, 1);

    // In-flight limit
    do_reset();
    gen_ready = 1'b1; idx = 0;
    for (int c = 0; c < 60; c++) begin
      pkt_valid = idx < 20; pkt_cmd = 1'b1; pkt_insn = 32'h1000 + idx;
      @(negedge clk);
      acc = pkt_valid && pkt_ready;
      cyc();
      if (acc) idx++;
    end
    pkt_valid = 1'b0;
    chk("lim_xfers", xfer_cnt, 16);
    chk("lim_pushed", idx, 20);
    chk("lim_inflight", inflight, 16);
    chk("lim_gen_vld", gen_vld, 0);
    chk("lim_full", pkt_ready, 0);
    retire = 2'b01;
    @(negedge clk);
    chk("lim_vld_at_retire", gen_vld, 0);
    cyc();
    retire = '0;
    @(negedge clk);
    chk("lim_vld_after_retire", gen_vld, 1);
    chk("lim_inflight_15", inflight, 15);
    cyc();
    chk("lim_xfers_17", xfer_cnt, 17);
    chk("lim_inflight_16", inflight, 16);

    // Normal drain, reset pulse and completion
    do_reset();
    gen_ready = 1'b1;
    drive_push(1'b1, 32'h00000013);
    drive_push(1'b1, 32'h00000033);
    drive_push(1'b0, 32'h0);
    repeat (5) cyc();
    chk("drain_core_rst", core_rst, 0);
    chk("drain_inflight", inflight, 2);
    chk("drain_gen_vld", gen_vld, 0);
    chk("drain_xfers", xfer_cnt, 2);
    rst_hi_cnt = 0; done_cnt = 0;
    retire = 2'b11;
    cyc();
    retire = '0;
    repeat (40) cyc();
    chk("seq_rst_cycles", rst_hi_cnt, 8);
    chk("seq_done_pulses", done_cnt, 1);
    chk("seq_err", err, 0);
    chk("seq_inflight", inflight, 0);
    drive_push(1'b1, 32'h000000b3);
    cyc();
    chk("next_trace_xfer", xfer_cnt, 3);
    rst_hi_cnt = 0; done_cnt = 0;
    retire = 2'b01;
    drive_push(1'b0, 32'h0);
    retire = '0;
    drive_push(1'b0, 32'h0);
    repeat (60) cyc();
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_rst_cycles", rst_hi_cnt, 16);
    chk("b2b_err", err, 0);

    // Drain timeout with retirements that never arrive
    do_reset();
    gen_ready = 1'b1;
    drive_push(1'b1, 32'h00000013);
    drive_push(1'b1, 32'h00000013);
    drive_push(1'b0, 32'h0);
    n = 0; seen = 1'b0; prev_err = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (core_rst) seen = 1'b1;
      else prev_err = err;
    end
    chk("to_reached", seen, 1);
    chk("to_cycles", n, 66);
    chk("to_err_before", prev_err, 0);
    chk("to_err_set", err, 1);
    chk("to_inflight_cleared", inflight, 0);
    done_cnt = 0;
    cyc();
    repeat (20) cyc();
    chk("to_done", done_cnt, 1);
    chk("to_err_sticky", err, 1);

    // Reset asserted in the middle of the core-reset phase
    do_reset();
    gen_ready = 1'b1;
    drive_push(1'b0, 32'h0);
    n = 0;
    while (!core_rst && n < 20) begin
      cyc();
      n++;
    end
    chk("mid_in_reset", core_rst, 1);
    drive_push(1'b1, 32'hdead0013);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pkt_ready", pkt_ready, 0);
    chk("mid_rst_core_rst", core_rst, 0);
    cyc();
    rst = 1'b0; done_cnt = 0;
    @(negedge clk);
    chk("mid_core_rst", core_rst, 0);
    chk("mid_inflight", inflight, 0);
    chk("mid_fifo_empty", gen_vld, 0);
    chk("mid_pkt_ready", pkt_ready, 1);
    cyc();
    repeat (20) cyc();
    chk("mid_no_done", done_cnt, 0);
    chk("mid_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
